// File: rtl/tdp_ram_be.sv
// True dual-port data memory with byte enables, selectable read-during-write, optional
// output register, deterministic cross-port collision handling and a post-reset clear sweep.
module tdp_ram_be #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset,
  output logic                init_busy,
  input  logic                en_a,
  input  logic [DATA_W/8-1:0] we_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   din_a,
  output logic [DATA_W-1:0]   dout_a,
  output logic                valid_a,
  input  logic                en_b,
  input  logic [DATA_W/8-1:0] we_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   din_b,
  output logic [DATA_W-1:0]   dout_b,
  output logic                valid_b,
  output logic                collision
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {StClear, StReady} state_e;
  localparam state_e StReset = (CLEAR_ON_RESET != 0) ? StClear : StReady;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                acc_a, acc_b;
  logic [DATA_W-1:0]   old_a, old_b, merged_a, merged_b, rdata_a, rdata_b;
  logic [DATA_W-1:0]   mem [Depth];

  logic [DATA_W-1:0]   dout_a1_q, dout_a1_d, dout_b1_q, dout_b1_d;
  logic                valid_a1_q, valid_a1_d, valid_b1_q, valid_b1_d;
  logic                coll1_q, coll1_d;

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = StReady;
      end
      StReady: ;
      default: state_d = StReady;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy = (state_q == StClear);
  assign acc_a     = (state_q == StReady) && en_a;
  assign acc_b     = (state_q == StReady) && en_b;

  // Port B lanes are written before port A so that A wins lanes written by both.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (acc_b && we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (acc_a && we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
      end
    end
  end

  // Write-first only merges the port's own bytes; cross-port readers always see old data.
  always_comb begin
    old_a    = mem[addr_a];
    old_b    = mem[addr_b];
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (we_a[i]) merged_a[8*i +: 8] = din_a[8*i +: 8];
      if (we_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
    end
    rdata_a = (RDW_MODE != 0) ? merged_a : old_a;
    rdata_b = (RDW_MODE != 0) ? merged_b : old_b;
  end

  always_comb begin
    dout_a1_d  = acc_a ? rdata_a : dout_a1_q;
    dout_b1_d  = acc_b ? rdata_b : dout_b1_q;
    valid_a1_d = acc_a;
    valid_b1_d = acc_b;
    coll1_d    = acc_a && acc_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_a1_q  <= '0;
      dout_b1_q  <= '0;
      valid_a1_q <= 1'b0;
      valid_b1_q <= 1'b0;
      coll1_q    <= 1'b0;
    end else begin
      dout_a1_q  <= dout_a1_d;
      dout_b1_q  <= dout_b1_d;
      valid_a1_q <= valid_a1_d;
      valid_b1_q <= valid_b1_d;
      coll1_q    <= coll1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] dout_a2_q, dout_a2_d, dout_b2_q, dout_b2_d;
    logic              valid_a2_q, valid_a2_d, valid_b2_q, valid_b2_d;
    logic              coll2_q, coll2_d;

    always_comb begin
      dout_a2_d  = valid_a1_q ? dout_a1_q : dout_a2_q;
      dout_b2_d  = valid_b1_q ? dout_b1_q : dout_b2_q;
      valid_a2_d = valid_a1_q;
      valid_b2_d = valid_b1_q;
      coll2_d    = coll1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dout_a2_q  <= '0;
        dout_b2_q  <= '0;
        valid_a2_q <= 1'b0;
        valid_b2_q <= 1'b0;
        coll2_q    <= 1'b0;
      end else begin
        dout_a2_q  <= dout_a2_d;
        dout_b2_q  <= dout_b2_d;
        valid_a2_q <= valid_a2_d;
        valid_b2_q <= valid_b2_d;
        coll2_q    <= coll2_d;
      end
    end

    assign dout_a    = dout_a2_q;
    assign dout_b    = dout_b2_q;
    assign valid_a   = valid_a2_q;
    assign valid_b   = valid_b2_q;
    assign collision = coll2_q;
  end else begin : g_no_out_reg
    assign dout_a    = dout_a1_q;
    assign dout_b    = dout_b1_q;
    assign valid_a   = valid_a1_q;
    assign valid_b   = valid_b1_q;
    assign collision = coll1_q;
  end

endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 32-bit/23-bit-address dual-port data memory.
- Adds per-byte write enables, per-port enable/valid, selectable read-during-write mode and an optional output register stage.
- Adds a deterministic cross-port collision policy and a post-reset memory-clear sequencer.
- Sits between the core load/store unit (port A) and DMA/debug (port B) as the data memory.

Parameters:
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged word).
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset release; 0 = no clear, array contents undefined.

Ports:
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-high.
- init_busy, out, 1, high while the clear sequencer runs.
- en_a, in, 1, port A access request.
- we_a, in, NB, port A byte write enables; byte i covers bits [8i+7:8i].
- addr_a, in, ADDR_W, port A word address.
- din_a, in, DATA_W, port A write data.
- dout_a, out, DATA_W, port A read data.
- valid_a, out, 1, pulses when dout_a holds data for an accepted access.
- en_b, we_b, addr_b, din_b, dout_b, valid_b: port B equivalents.
- collision, out, 1, pulses when an accepted cross-port conflict occurred.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While reset is high: dout_a/dout_b = 0, valid_a/valid_b = 0, collision = 0, pipeline registers = 0, sequencer in CLEAR with counter = 0.
- init_busy = 1 in reset when CLEAR_ON_RESET = 1; otherwise 0.
- Sequencer states CLEAR -> READY:
  - CLEAR writes 0 to address cnt each cycle, then cnt++.
  - At cnt = DEPTH-1 the last word is written and the next state is READY.
  - init_busy falls on the first READY cycle, exactly DEPTH cycles after reset deassertion.
  - With CLEAR_ON_RESET = 0, leave reset directly into READY.
  - Reset asserted mid-clear aborts and restarts the sweep from 0 on release.
- In CLEAR, en_a/en_b are ignored: no writes, valid stays 0, dout holds 0.
- Accepted access (READY and en_x = 1):
  - Each byte with we_x[i] = 1 is written.
  - A read is always performed, with or without writes.
  - en_x = 0 means no memory access; dout_x holds its last value and valid_x = 0.
- Latency:
  - OUT_REG = 0: dout_x/valid_x update on the edge that accepts the access (visible the next cycle).
  - OUT_REG = 1: one cycle later.
  - Fully pipelined: one access per port per cycle, no stalls.
- Same-port read-during-write:
  - RDW_MODE = 0 returns the pre-write word.
  - RDW_MODE = 1 returns the merged word: new bytes where we = 1, old bytes elsewhere.
- Cross-port, same address, both accepted:
  - Both write: per-byte merge; for lanes written by both, port A wins.
  - One writes, the other reads: the reader gets the old word regardless of RDW_MODE.
  - collision = 1 when addresses match and |we_a or |we_b; aligned with valid (same latency).
  - Read/read at the same address is not a collision.
- Addresses are exactly ADDR_W wide; no wrap or out-of-range case exists.

Test Plan:
- Reset, CLEAR_ON_RESET = 1, ADDR_W = 4 -> init_busy high for 16 cycles after release; afterwards reads of 0..15 all return 0. Port A request during busy -> valid_a stays 0 and memory is untouched.
- Port A write 0xDDCCBBAA to addr 3 (we = 4'hF), then we = 4'b0101 with din 0x11223344 -> read addr 3 returns 0xDD22BB44, valid_a 1 cycle after the read (OUT_REG = 0), 2 cycles after (OUT_REG = 1).
- RDW_MODE = 0, addr 5 holds 0x0; same cycle write 0xCAFEF00D on port A -> dout_a = 0x0. RDW_MODE = 1 -> dout_a = 0xCAFEF00D.
- Same cycle, addr 7: A writes 0xAAAAAAAA (we = 4'b0011), B writes 0xBBBBBBBB (we = 4'b0110) -> addr 7 = 0x00BBAAAA (from cleared state); collision pulses for 1 cycle.
- Same cycle, addr 9 holds 0x12345678: B writes 0x0 (all bytes), A reads -> dout_a = 0x12345678, collision = 1. Next-cycle A read -> 0x0, collision = 0.
- Assert reset at cnt = 8 of the clear sweep -> outputs are 0 immediately (async). After release, init_busy stays high a full DEPTH cycles.
